// File: rtl/spi_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_pkg
// Description : Shared constants, FSM state encoding and helpers for the
//               SPI command controller.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_cmd_pkg;

  // Register file geometry
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] CLEAR_ADDR  = ADDR_W'(6);

  // Command byte layout: {wr, reserved[3:0], addr[2:0]}
  localparam int CMD_WR_BIT   = 7;
  localparam int CMD_RSV_MSB  = 6;
  localparam int CMD_RSV_LSB  = 3;
  localparam int CMD_ADDR_MSB = ADDR_W - 1;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CMD  = 2'd1;
  localparam state_t ST_DATA = 2'd2;
  localparam state_t ST_DROP = 2'd3;

  // Saturating increment for the error counter
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cmd_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_sync
// Description : Multi-flop synchronizer with rising/falling edge detect.
//               Edges are suppressed until the chain holds only real samples
//               after reset, so reset values never produce a false edge.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic valid
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic [STAGES:0]   r_fill;

  // Shift the async input through the chain; track how much is real data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], async_in};
      r_prev <= r_sync[STAGES-1];
      r_fill <= {r_fill[STAGES-1:0], 1'b1};
    end
  end

  assign level = r_sync[STAGES-1];
  assign valid = r_fill[STAGES];
  assign rise  = valid &  level & ~r_prev;
  assign fall  = valid & ~level &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_ctrl
// Description : Command decoder behind an SPI slave. Byte 0 of a frame is a
//               command {wr, rsv[3:0], addr[2:0]}; later bytes write or read
//               an 8x8 register file whose address 7 is the error counter.
//               Optional macro SPI_CMD_AUTOINC_EN enables burst access with
//               address auto-increment; otherwise one data byte per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] TX_IDLE     = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce0,
  input  logic       ssig,
  input  logic [7:0] rx_data,
  output logic [7:0] tx_data,
  output logic [7:0] cfg0,
  output logic [3:0] led,
  output logic       busy
);
  import spi_cmd_pkg::*;

  logic              w_byte_stb;
  logic              w_ssig_lvl_unused;
  logic              w_ssig_fall_unused;
  logic              w_ssig_valid_unused;
  logic              w_ce0_lvl;
  logic              w_ce0_rise;
  logic              w_ce0_fall;
  logic              w_ce0_valid;
  logic              r_ce0_armed;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic [7:0]        r_tx;
  logic [7:0]        r_err_cnt;
  logic [7:0]        r_regs [0:NREG-1];

  logic [ADDR_W-1:0] w_cmd_addr;
  logic              w_cmd_bad;
  logic [7:0]        w_cmd_rd;

  spi_cmd_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ssig (
    .clk      (clk),
    .rst      (rst),
    .async_in (ssig),
    .level    (w_ssig_lvl_unused),
    .rise     (w_byte_stb),
    .fall     (w_ssig_fall_unused),
    .valid    (w_ssig_valid_unused)
  );

  spi_cmd_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ce0 (
    .clk      (clk),
    .rst      (rst),
    .async_in (ce0),
    .level    (w_ce0_lvl),
    .rise     (w_ce0_rise),
    .fall     (w_ce0_fall),
    .valid    (w_ce0_valid)
  );

  // A ce0 fall only starts a frame once ce0 has really been seen high, so a
  // reset released mid-frame waits for the next genuine frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ce0_armed <= 1'b0;
    else     r_ce0_armed <= r_ce0_armed | (w_ce0_valid & w_ce0_lvl);
  end

  assign w_cmd_addr = rx_data[CMD_ADDR_MSB:0];
  assign w_cmd_bad  = |rx_data[CMD_RSV_MSB:CMD_RSV_LSB];

  // Read data for the address carried in the command byte
  always_comb begin
    w_cmd_rd = (w_cmd_addr == STATUS_ADDR) ? r_err_cnt : r_regs[w_cmd_addr];
  end

`ifdef SPI_CMD_AUTOINC_EN
  logic [ADDR_W-1:0] w_nxt_addr;
  logic [7:0]        w_nxt_rd;
  assign w_nxt_addr = r_addr + ADDR_W'(1);
  // Read data for the following burst address
  always_comb begin
    w_nxt_rd = (w_nxt_addr == STATUS_ADDR) ? r_err_cnt : r_regs[w_nxt_addr];
  end
`endif

  // Frame FSM, register file and error counter; ce0 edges take priority over
  // a same-cycle byte strobe, which is then discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_tx      <= TX_IDLE;
      r_err_cnt <= 8'h00;
      for (int i = 0; i < NREG; i++) r_regs[i] <= 8'h00;
    end else if (w_ce0_rise) begin
      r_state <= ST_IDLE;
      r_tx    <= TX_IDLE;
    end else if (w_ce0_fall && r_ce0_armed) begin
      r_state <= ST_CMD;
      r_tx    <= TX_IDLE;
    end else if (w_byte_stb) begin
      case (r_state)
        ST_CMD: begin
          if (w_cmd_bad) begin
            r_state   <= ST_DROP;
            r_tx      <= TX_IDLE;
            r_err_cnt <= sat_inc(r_err_cnt);
          end else begin
            r_state <= ST_DATA;
            r_addr  <= w_cmd_addr;
            r_wr    <= rx_data[CMD_WR_BIT];
            r_tx    <= rx_data[CMD_WR_BIT] ? TX_IDLE : w_cmd_rd;
          end
        end
        ST_DATA: begin
          if (r_wr) begin
            if (r_addr == STATUS_ADDR) begin
              r_err_cnt <= sat_inc(r_err_cnt);
            end else begin
              r_regs[r_addr] <= rx_data;
              if (r_addr == CLEAR_ADDR) r_err_cnt <= 8'h00;
            end
          end
`ifdef SPI_CMD_AUTOINC_EN
          r_addr <= w_nxt_addr;
          r_tx   <= r_wr ? TX_IDLE : w_nxt_rd;
`else
          r_state <= ST_DROP;
          r_tx    <= TX_IDLE;
`endif
        end
        default: ;
      endcase
    end
  end

  assign tx_data = r_tx;
  assign cfg0    = r_regs[0];
  assign led     = r_regs[1][3:0];
  assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_cmd_ctrl
// Description : Scoreboard bench for spi_cmd_ctrl. Stimulus drives SPI
//               frames and queues expected output values; a monitor drains
//               the queue half a cycle later and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_ctrl;

  localparam int SS = 2;

  localparam int SIG_CFG0 = 0;
  localparam int SIG_LED  = 1;
  localparam int SIG_TX   = 2;
  localparam int SIG_BUSY = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce0;
  logic       ssig;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic [7:0] cfg0;
  logic [3:0] led;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    int         sig;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];

  spi_cmd_ctrl #(.SYNC_STAGES(SS), .TX_IDLE(8'h00)) dut (
    .clk     (clk),
    .rst     (rst),
    .ce0     (ce0),
    .ssig    (ssig),
    .rx_data (rx_data),
    .tx_data (tx_data),
    .cfg0    (cfg0),
    .led     (led),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] sample(input int s);
    case (s)
      SIG_CFG0: return cfg0;
      SIG_LED:  return {4'h0, led};
      SIG_TX:   return tx_data;
      default:  return {7'h00, busy};
    endcase
  endfunction

  // Monitor: compare every queued expectation shortly after the falling edge
  always begin
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = sb.pop_front();
      act = sample(e.sig);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_val(input string n, input int s, input logic [7:0] v);
    exp_t e;
    e.name = n;
    e.sig  = s;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic start_frame();
    ce0 = 1'b0;
    repeat (SS + 3) @(negedge clk);
  endtask

  task automatic end_frame();
    ce0 = 1'b1;
    repeat (SS + 3) @(negedge clk);
  endtask

  // One SPI byte: byte_stb and its effect land within SS+2 clocks of ssig
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    ssig    = 1'b1;
    repeat (SS + 2) @(negedge clk);
    ssig    = 1'b0;
    repeat (SS + 2) @(negedge clk);
  endtask

  // Read one register: its value is on tx_data while the next byte shifts
  task automatic read_reg(input logic [2:0] a, input logic [7:0] v, input string n);
    start_frame();
    send_byte({5'b00000, a});
    expect_val(n, SIG_TX, v);
    send_byte(8'h00);
    end_frame();
  endtask

  initial begin
    rst     = 1'b1;
    ce0     = 1'b1;
    ssig    = 1'b0;
    rx_data = 8'h00;
    repeat (2) @(negedge clk);
    expect_val("rst_cfg0", SIG_CFG0, 8'h00);
    expect_val("rst_led",  SIG_LED,  8'h00);
    expect_val("rst_busy", SIG_BUSY, 8'h00);
    expect_val("rst_tx",   SIG_TX,   8'h00);
    rst = 1'b0;
    repeat (SS + 4) @(negedge clk);

    // Single write to register 0
    start_frame();
    expect_val("frame_busy", SIG_BUSY, 8'h01);
    send_byte(8'h80);
    rx_data = 8'h5A;
    ssig    = 1'b1;
    repeat (SS + 2) @(negedge clk);
    expect_val("wr_cfg0", SIG_CFG0, 8'h5A);
    ssig    = 1'b0;
    repeat (SS + 2) @(negedge clk);
    end_frame();
    expect_val("idle_busy", SIG_BUSY, 8'h00);
    expect_val("idle_tx",   SIG_TX,   8'h00);

    // Write register 1 then read it back
    start_frame();
    send_byte(8'h81);
    send_byte(8'hA5);
    end_frame();
    expect_val("wr_led", SIG_LED, 8'h05);
    read_reg(3'd1, 8'hA5, "rd_reg1_tx");
    expect_val("rd_after_tx", SIG_TX, 8'h00);

    // Bad command: reserved bits set
    start_frame();
    send_byte(8'hC8);
    send_byte(8'h11);
    expect_val("drop_busy", SIG_BUSY, 8'h01);
    expect_val("drop_tx",   SIG_TX,   8'h00);
    end_frame();
    expect_val("drop_cfg0", SIG_CFG0, 8'h5A);
    expect_val("drop_led",  SIG_LED,  8'h05);
    read_reg(3'd7, 8'h01, "err_cnt_1");

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      start_frame();
      send_byte(8'hC8);
      end_frame();
    end
    read_reg(3'd7, 8'hFF, "err_cnt_sat");
    read_reg(3'd7, 8'hFF, "err_cnt_keep");

`ifdef SPI_CMD_AUTOINC_EN
    // Burst: addr 6 (clears err), addr 7 (counted), wrap to addr 0
    start_frame();
    send_byte(8'h86);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    end_frame();
    expect_val("burst_cfg0", SIG_CFG0, 8'h30);
    read_reg(3'd6, 8'h10, "burst_reg6");
    read_reg(3'd7, 8'h01, "burst_err");
`else
    // Write to addr 6 clears err; extra byte ignored without error
    start_frame();
    send_byte(8'h86);
    send_byte(8'h33);
    send_byte(8'h44);
    end_frame();
    read_reg(3'd7, 8'h00, "clr_err");
    read_reg(3'd6, 8'h33, "clr_reg6");
    // Write to status address is counted
    start_frame();
    send_byte(8'h87);
    send_byte(8'h12);
    end_frame();
    read_reg(3'd7, 8'h01, "wr7_err");
    // Only the first data byte of a frame is written
    start_frame();
    send_byte(8'h80);
    send_byte(8'h77);
    send_byte(8'h99);
    end_frame();
    expect_val("single_cfg0", SIG_CFG0, 8'h77);
    read_reg(3'd7, 8'h01, "single_err");
`endif

    // Abort: ce0 rises together with the write data byte
    start_frame();
    send_byte(8'h81);
    rx_data = 8'hEE;
    ssig    = 1'b1;
    ce0     = 1'b1;
    repeat (SS + 3) @(negedge clk);
    expect_val("abort_led",  SIG_LED,  8'h05);
    expect_val("abort_busy", SIG_BUSY, 8'h00);
    expect_val("abort_tx",   SIG_TX,   8'h00);
    ssig = 1'b0;
    repeat (SS + 2) @(negedge clk);

    // Reset in the middle of a frame
    start_frame();
    send_byte(8'h81);
    rst = 1'b1;
    expect_val("mrst_cfg0", SIG_CFG0, 8'h00);
    expect_val("mrst_led",  SIG_LED,  8'h00);
    expect_val("mrst_busy", SIG_BUSY, 8'h00);
    expect_val("mrst_tx",   SIG_TX,   8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (SS + 4) @(negedge clk);
    send_byte(8'h77);
    expect_val("post_rst_led",  SIG_LED,  8'h00);
    expect_val("post_rst_busy", SIG_BUSY, 8'h00);
    end_frame();
    start_frame();
    send_byte(8'h80);
    send_byte(8'h5A);
    end_frame();
    expect_val("post_rst_cfg0", SIG_CFG0, 8'h5A);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for ssig and ce0 (legal range 2..3).
REQ-002 SHALL have parameter TX_IDLE, default 8'h00, meaning the tx_data value outside read phases.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single system clock; all logic is in this domain.
REQ-004 SHALL have port rst, input, 1 bit, meaning asynchronous active-high reset.
REQ-005 SHALL have port ce0, input, 1 bit, meaning active-low chip enable, asynchronous to clk.
REQ-006 SHALL have port ssig, input, 1 bit, meaning the SPI slave byte-complete flag, asynchronous to clk.
REQ-007 SHALL have port rx_data, input, 8 bits, meaning the last received SPI byte, stable from ssig rise until the next byte completes.
REQ-008 SHALL have port tx_data, output, 8 bits, meaning the byte the SPI slave shifts out on the next transfer.
REQ-009 SHALL have port cfg0, output, 8 bits, meaning the contents of register 0.
REQ-010 SHALL have port led, output, 4 bits, meaning register 1 bits [3:0].
REQ-011 SHALL have port busy, output, 1 bit, meaning the FSM is not IDLE.

Function
REQ-012 ssig and ce0 SHALL each pass through a SYNC_STAGES flop synchronizer; byte_stb SHALL be a one-clk pulse on the synchronized ssig rising edge.
REQ-013 rx_data SHALL be captured on the byte_stb cycle.
REQ-014 Register file: 8 x 8-bit; addresses 0..6 read/write; address 7 is read-only status = err_cnt.
REQ-015 Frame: synchronized ce0 low; byte 0 is the command: bit7 = 1 write / 0 read, bits[6:3] reserved (must be 0), bits[2:0] address.
REQ-016 FSM states: IDLE, CMD, DATA, DROP.
REQ-017 IDLE->CMD on synchronized ce0 falling edge.
REQ-018 CMD->DATA on byte_stb with valid command; the address SHALL be latched.
REQ-019 CMD->DROP on byte_stb with nonzero reserved bits.
REQ-020 From any state, synchronized ce0 rising SHALL force IDLE and tx_data = TX_IDLE, regardless of a same-cycle byte_stb; that byte is discarded.
REQ-021 Read: tx_data SHALL equal reg[addr] one clk after the command byte_stb and after each subsequent DATA byte_stb (next address).
REQ-022 Write: on each DATA byte_stb, reg[addr] <= rx_data, visible on cfg0/led the next clk.
REQ-023 A write to address 7 SHALL be ignored and SHALL increment err_cnt.
REQ-024 Each entry to DROP SHALL increment err_cnt; err_cnt SHALL saturate at 8'hFF.
REQ-025 DROP SHALL ignore all bytes and keep tx_data = TX_IDLE until ce0 deasserts.
REQ-026 Read-out SHALL NOT clear err_cnt; a write of any value to address 6 SHALL also clear err_cnt (reg6 still stores the value).
REQ-027 If ce0 falls while not IDLE (glitch), the FSM SHALL restart in CMD.

Reset
REQ-028 rst SHALL asynchronously clear the FSM to IDLE, all registers and err_cnt to 0, tx_data to TX_IDLE, synchronizer flops to ssig = 0 and ce0 = 1.
REQ-029 Reset deassertion mid-frame SHALL leave the FSM in IDLE until the next ce0 falling edge.
REQ-030 After reset: cfg0 = 0, led = 0, busy = 0.

Configuration
REQ-031 With macro SPI_CMD_AUTOINC_EN defined, each DATA byte after the first SHALL advance addr by 1, wrapping 7->0 (burst access).
REQ-032 Without SPI_CMD_AUTOINC_EN, the first DATA byte SHALL move the FSM to DROP without incrementing err_cnt; later bytes are ignored.

Structure
REQ-033 A shared package spi_cmd_pkg SHALL hold the FSM state enum, command bit positions, ADDR_W = 3, NREG = 8 and STATUS_ADDR = 7.
REQ-034 Sub-module spi_cmd_sync SHALL implement one synchronizer with edge detect, instanced twice.

Verification
REQ-035 Write: frame {8'h80, 8'h5A} -> cfg0 = 8'h5A within SYNC_STAGES+2 clk of the second ssig.
REQ-036 Readback: {8'h81, 8'hA5} then {8'h01, 8'h00} -> led = 4'h5; tx_data = 8'hA5 during the second byte of frame 2.
REQ-037 Bad command: frame {8'hC8, 8'h11} -> no register change; reg7 read = 8'h01; 300 bad frames -> reg7 = 8'hFF.
REQ-038 Burst (SPI_CMD_AUTOINC_EN): {8'h86, 8'h10, 8'h20, 8'h30} -> reg6 = 8'h10, err_cnt cleared, write to addr 7 counted (err_cnt = 1), reg0 = 8'h30.
REQ-039 Abort: ce0 rises on the same clk as byte_stb of a write data byte -> register unchanged, busy = 0, tx_data = 8'h00.
REQ-040 Reset mid-frame after the command byte -> all outputs 0 immediately; the next full frame behaves per REQ-035.
